// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, largest legal digit value, and a
// validity check used wherever raw nibbles enter the counter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic logic digit_valid(input bcd_digit_t digit);
    return digit <= BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the counter chain: applies a +1/-1 step when step_in is
// set and reports a carry/borrow to the next more significant digit.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       step_in,
  input  logic       up,
  output bcd_digit_t next_digit,
  output logic       step_out
);

  // NOTE: defaults first so every path assigns both outputs; no latch inferred.
  always_comb begin
    next_digit = digit;
    step_out   = 1'b0;
    if (step_in) begin
      if (dir_e'(up) == DIR_UP) begin
        // ">=" also steers an illegal nibble back to 0 instead of counting on.
        if (digit >= BCD_MAX_DIGIT) begin
          next_digit = '0;
          step_out   = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (digit == '0) begin
          next_digit = BCD_MAX_DIGIT;
          step_out   = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with clear, validated parallel load and
// either wrap-around or saturation at the terminal count.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SATURATE = 0
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_clear,
  input  logic                            i_load,
  input  logic [N_DIGITS*BCD_DIGIT_W-1:0] i_load_val,
  input  logic                            i_en,
  input  logic                            i_up,
  output logic [N_DIGITS*BCD_DIGIT_W-1:0] o_count,
  output logic                            o_wrap,
  output logic                            o_sat,
  output logic                            o_load_err
);

  localparam int W = N_DIGITS * BCD_DIGIT_W;

  logic [W-1:0]      count_q;
  logic [W-1:0]      count_next;
  logic [N_DIGITS:0] step;
  logic              wrap_q;
  logic              load_err_q;
  logic              load_ok;
  logic              at_max;
  logic              at_min;

  // Step chain: digit 0 steps on enable, digit k steps on the ripple from k-1.
  assign step[0] = i_en;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_digit_step u_step (
      .digit     (count_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .step_in   (step[g]),
      .up        (i_up),
      .next_digit(count_next[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .step_out  (step[g+1])
    );
  end

  always_comb begin
    load_ok = 1'b1;
    at_max  = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!digit_valid(i_load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W])) load_ok = 1'b0;
      if (count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] != BCD_MAX_DIGIT) at_max = 1'b0;
    end
  end

  assign at_min = (count_q == '0);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      if (i_clear) begin
        count_q <= '0;
      end else if (i_load) begin
        if (load_ok) count_q    <= i_load_val;
        else         load_err_q <= 1'b1;
      end else if (i_en) begin
        // Carry/borrow out of the top digit means the terminal count was reached.
        if (!step[N_DIGITS]) begin
          count_q <= count_next;
        end else if (SATURATE == 0) begin
          count_q <= count_next;
          wrap_q  <= 1'b1;
        end
      end
    end
  end

  assign o_count    = count_q;
  assign o_wrap     = wrap_q;
  assign o_load_err = load_err_q;
  assign o_sat      = (SATURATE != 0) && (i_up ? at_max : at_min);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: a wrapping and a saturating counter share stimulus and
// are compared against an integer-arithmetic reference model.
module tb_bcd_updown_counter;

  localparam int N    = 4;
  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear, load, en, up;
  logic [15:0] load_val;

  logic [15:0] count_w, count_s;
  logic        wrap_w, wrap_s, sat_w, sat_s, lerr_w, lerr_s;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: counts held as plain integers 0..9999.
  int  v_w, v_s;
  bit  ew_w, ew_s, ele_w, ele_s;

  always #5 clk = ~clk;

  bcd_updown_counter #(.N_DIGITS(N), .SATURATE(0)) dut_wrap (
    .i_clk(clk), .i_reset(rst), .i_clear(clear), .i_load(load),
    .i_load_val(load_val), .i_en(en), .i_up(up),
    .o_count(count_w), .o_wrap(wrap_w), .o_sat(sat_w), .o_load_err(lerr_w)
  );

  bcd_updown_counter #(.N_DIGITS(N), .SATURATE(1)) dut_sat (
    .i_clk(clk), .i_reset(rst), .i_clear(clear), .i_load(load),
    .i_load_val(load_val), .i_en(en), .i_up(up),
    .o_count(count_s), .o_wrap(wrap_s), .o_sat(sat_s), .o_load_err(lerr_s)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] b);
    for (int i = 0; i < N; i++) if (b[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(b[i*4 +: 4]);
    return r;
  endfunction

  function automatic void ref_step(input bit sat, input int v_in,
                                   output int v_out, output bit w, output bit le);
    v_out = v_in;
    w     = 1'b0;
    le    = 1'b0;
    if (clear) begin
      v_out = 0;
    end else if (load) begin
      if (bcd_ok(load_val)) v_out = from_bcd(load_val);
      else                  le    = 1'b1;
    end else if (en) begin
      if (up) begin
        if (v_in == MAXV) begin
          if (!sat) begin v_out = 0; w = 1'b1; end
        end else v_out = v_in + 1;
      end else begin
        if (v_in == 0) begin
          if (!sat) begin v_out = MAXV; w = 1'b1; end
        end else v_out = v_in - 1;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_cnt_w"},  count_w, to_bcd(v_w));
    check({tag, "_wrap_w"}, 16'(wrap_w), 16'(ew_w));
    check({tag, "_lerr_w"}, 16'(lerr_w), 16'(ele_w));
    check({tag, "_sat_w"},  16'(sat_w), 16'h0);
    check({tag, "_cnt_s"},  count_s, to_bcd(v_s));
    check({tag, "_wrap_s"}, 16'(wrap_s), 16'h0);
    check({tag, "_lerr_s"}, 16'(lerr_s), 16'(ele_s));
    check({tag, "_sat_s"},  16'(sat_s), 16'(up ? (v_s == MAXV) : (v_s == 0)));
  endtask

  // Apply current inputs across one rising edge, then compare #1 later.
  task automatic tick(input string tag);
    int nw, ns;
    ref_step(1'b0, v_w, nw, ew_w, ele_w);
    ref_step(1'b1, v_s, ns, ew_s, ele_s);
    @(posedge clk);
    #1;
    v_w = nw;
    v_s = ns;
    check_all(tag);
  endtask

  task automatic drive(input logic c, input logic l, input logic [15:0] lv,
                       input logic e, input logic u);
    clear = c; load = l; load_val = lv; en = e; up = u;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 16'h0, 0, 0);
    v_w = 0; v_s = 0; ew_w = 0; ew_s = 0; ele_w = 0; ele_s = 0;
    #3;
    check_all("reset");
    #4 rst = 1'b0;

    // Ripple carry across several digits.
    drive(0, 1, 16'h0998, 0, 1); tick("ld0998");
    drive(0, 0, 16'h0, 1, 1);
    tick("up1"); check("up1_const", count_w, 16'h0999);
    tick("up2"); check("up2_const", count_w, 16'h1000);
    tick("up3"); check("up3_const", count_w, 16'h1001);

    // Wrap up then wrap down; saturating copy holds then leaves the limit.
    drive(0, 1, 16'h9999, 0, 1); tick("ld9999");
    drive(0, 0, 16'h0, 1, 1);    tick("wrap_up");
    check("wrap_up_const", count_w, 16'h0000);
    check("wrap_up_pulse", 16'(wrap_w), 16'h1);
    drive(0, 0, 16'h0, 1, 0);    tick("wrap_dn");
    check("wrap_dn_const", count_w, 16'h9999);
    drive(0, 0, 16'h0, 0, 0);    tick("idle");
    check("idle_nopulse", 16'(wrap_w), 16'h0);

    // Saturation hold for five cycles, then direction flip.
    drive(0, 1, 16'h9999, 0, 1); tick("sat_ld");
    drive(0, 0, 16'h0, 1, 1);
    for (int i = 0; i < 5; i++) tick("sat_hold");
    check("sat_hold_const", count_s, 16'h9999);
    check("sat_level", 16'(sat_s), 16'h1);
    up = 1'b0;
    #1;
    check("sat_flip_comb", 16'(sat_s), 16'h0);
    tick("sat_release");
    check("sat_release_const", count_s, 16'h9998);

    // Rejected load, then a legal one.
    drive(0, 1, 16'h12A4, 0, 0); tick("bad_load");
    check("bad_load_err", 16'(lerr_w), 16'h1);
    drive(0, 1, 16'h1234, 0, 0); tick("good_load");
    check("good_load_const", count_w, 16'h1234);
    check("good_load_noerr", 16'(lerr_w), 16'h0);

    // Priority: clear over load over enable.
    drive(0, 1, 16'h0500, 0, 0); tick("ld0500");
    drive(1, 1, 16'h0777, 1, 1); tick("prio_clear");
    check("prio_clear_const", count_w, 16'h0000);
    drive(0, 1, 16'h0777, 1, 1); tick("prio_load");
    check("prio_load_const", count_w, 16'h0777);

    // Asynchronous reset between edges while counting.
    drive(0, 1, 16'h0042, 0, 1); tick("ld0042");
    drive(0, 0, 16'h0, 1, 1);    tick("cnt43");
    #2 rst = 1'b1;
    #1;
    v_w = 0; v_s = 0; ew_w = 0; ew_s = 0; ele_w = 0; ele_s = 0;
    check_all("async_rst");
    check("async_rst_const", count_w, 16'h0000);
    @(posedge clk); #1;
    check_all("rst_held");
    #2 rst = 1'b0;
    tick("after_rst");
    check("after_rst_const", count_w, 16'h0001);

    // Randomized traffic, biased toward the terminal counts.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel      = int'($urandom_range(0, 15));
      clear    = (sel == 0);
      load     = (sel < 4);
      en       = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom());
      case ($urandom_range(0, 4))
        0:       load_val = 16'h9999;
        1:       load_val = 16'h0000;
        2:       load_val = 16'($urandom());
        default: load_val = to_bcd(int'($urandom_range(0, MAXV)));
      endcase
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter N_DIGITS, default 4, number of BCD digits (1..8).
REQ-002 Parameter SATURATE, default 0; 0 = wrap at terminal count, 1 = hold at terminal count.
REQ-003 i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 i_reset  input  1  reset, asynchronous and active-high.
REQ-005 i_clear  input  1  synchronous clear to zero.
REQ-006 i_load  input  1  synchronous parallel load request.
REQ-007 i_load_val  input  4*N_DIGITS  load value, digit 0 in bits [3:0].
REQ-008 i_en  input  1  count enable.
REQ-009 i_up  input  1  direction; 1 = increment, 0 = decrement.
REQ-010 o_count  output  4*N_DIGITS  registered BCD count, digit 0 least significant.
REQ-011 o_wrap  output  1  one-cycle pulse on rollover (9..9->0..0 up, 0..0->9..9 down).
REQ-012 o_sat  output  1  level; high while SATURATE=1 and count pinned at its limit in the current direction.
REQ-013 o_load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-014 Priority per cycle: i_clear > i_load > i_en; lower-priority requests in the same cycle are ignored.
REQ-015 i_clear: o_count <= 0 next edge; o_wrap = 0; o_load_err = 0.
REQ-016 i_load with every digit of i_load_val in 0..9: o_count <= i_load_val next edge.
REQ-017 i_load with any digit 10..15: o_count unchanged, o_load_err pulses high for exactly one cycle.
REQ-018 i_en, i_up=1: digit 0 +1; digit k increments only when all lower digits were 9 (ripple carry); digit 9 -> 0 with carry.
REQ-019 i_en, i_up=0: digit 0 -1; digit k decrements only when all lower digits were 0 (ripple borrow); digit 0 -> 9 with borrow.
REQ-020 Latency: one clock from sampled request to updated o_count; o_wrap/o_load_err registered, aligned with the o_count update they describe.
REQ-021 SATURATE=0: carry/borrow out of the top digit wraps the count and pulses o_wrap for one cycle.
REQ-022 SATURATE=1: up at all-9s and down at all-0s leave o_count unchanged; o_wrap never asserts.
REQ-023 o_sat (SATURATE=1 only) is combinational from o_count and i_up: high when (i_up and all 9s) or (!i_up and all 0s); tied 0 when SATURATE=0.
REQ-024 i_en=0 with no clear/load: o_count holds, pulse outputs low.
REQ-025 o_count never holds a non-BCD digit under any input sequence.

Reset
REQ-026 i_reset high asynchronously forces o_count = 0, o_wrap = 0, o_load_err = 0, independent of i_clk.
REQ-027 Reset asserted mid-count aborts the operation; first edge after deassertion obeys REQ-014 on then-current inputs.

Structure
REQ-028 Shared package bcd_pkg holds BCD_DIGIT_W = 4, BCD_MAX_DIGIT = 9 and a digit-validity function.
REQ-029 One sub-module bcd_digit_step: combinational single digit, inputs digit, step-in, direction; outputs next digit, step-out; instantiated N_DIGITS times in a generate chain.
REQ-030 All state in one register bank for o_count plus two pulse flops; no other state.

Verification (N_DIGITS=4)
REQ-031 Load 0x0998, up, en 3 cycles -> o_count 0x0999, 0x1000, 0x1001; o_wrap stays 0.
REQ-032 SATURATE=0: load 0x9999, up, en 1 cycle -> o_count 0x0000, o_wrap one-cycle pulse; then down 1 cycle -> 0x9999, o_wrap pulses again.
REQ-033 SATURATE=1: load 0x9999, up, en 5 cycles -> o_count stays 0x9999, o_sat = 1, o_wrap = 0; flip i_up=0 -> o_sat = 0, next edge 0x9998.
REQ-034 Load 0x12A4 -> o_count unchanged, o_load_err high exactly one cycle; next load 0x1234 -> o_count 0x1234, no error.
REQ-035 Same cycle i_clear=1, i_load=1, i_en=1 with count 0x0500 -> o_count 0x0000; i_load=1 with i_en=1 -> load wins.
REQ-036 Assert i_reset between clock edges while counting from 0x0042 -> o_count 0x0000 immediately; release -> counting resumes from 0x0000 on next enabled edge.
